// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: operation/state enums, address defaults and lane insert/extract helpers
package lsu_pkg;
    typedef enum logic [2:0] {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH} op_e;
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;
    localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;
    localparam int unsigned DEPTH_DEF     = 800;
    function automatic logic is_rmw(input op_e op);
        return op == OP_SB || op == OP_SH;
    endfunction
    function automatic logic [31:0] lane_insert(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] lane, input op_e op);
        logic [31:0] w;
        w = word;
        if (op == OP_SB)
            w[8*lane +: 8] = wdata[7:0];
        else if (op == OP_SH)
            w[16*lane[1] +: 16] = wdata[15:0];
        else
            w = wdata;
        return w;
    endfunction
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input op_e op);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = word[16*lane[1] +: 16];
        return op == OP_LB  ? {{24{b[7]}}, b}  :
               op == OP_LBU ? {24'h0, b}       :
               op == OP_LH  ? {{16{h[15]}}, h} :
               op == OP_LHU ? {16'h0, h}       : word;
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// lsu_if: CPU-side request/response handshake between pipeline (master) and LSU (slave)
interface lsu_if
    import lsu_pkg::*;
();
    logic        req_valid;
    logic        req_ready;
    op_e         req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (output req_valid, req_op, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_op, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/load_store_unit_lane_merge.sv
// lsu_lane_merge: combinational byte/half insert for RMW stores and extract+extend for loads
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  op_e         i_op,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);
    assign o_merged = lane_insert(i_word, i_wdata, i_lane, i_op);
    assign o_load   = lane_extract(i_word, i_lane, i_op);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for word-only data memory; byte/half via lane select and RMW.
// Build option LSU_MISALIGN_TRAP_EN sends misaligned LH/LHU/SH/LW/SW down the error path.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DATA_BASE_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    lsu_if.slave        bus,
    output logic        d_ram_rena,
    output logic        d_ram_wena,
    output logic [31:0] DAddr,
    output logic [31:0] DataIn,
    input  logic [31:0] Data_out
);
    state_e      r_state, w_next;
    op_e         r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata, r_rdata, r_daddr, r_datain;
    logic        r_err;
    logic [31:0] w_woff, w_merged, w_load;
    logic        w_oor, w_mis, w_err, w_accept;

    assign w_woff   = (bus.req_addr - DATA_BASE) >> 2;
    assign w_oor    = (bus.req_addr < DATA_BASE) || (w_woff >= DEPTH);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis    = ((bus.req_op == OP_LH || bus.req_op == OP_LHU || bus.req_op == OP_SH) && bus.req_addr[0]) ||
                      ((bus.req_op == OP_LW || bus.req_op == OP_SW) && bus.req_addr[1:0] != 2'b00);
`else
    assign w_mis    = 1'b0;
`endif
    assign w_err    = w_oor || w_mis;
    assign w_accept = bus.req_valid && r_state == S_IDLE;

    assign bus.req_ready  = r_state == S_IDLE;
    assign bus.resp_valid = r_state == S_RESP;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign d_ram_rena     = r_state == S_RD;
    assign d_ram_wena     = r_state == S_WR;
    assign DAddr          = r_daddr;
    assign DataIn         = r_datain;

    lsu_lane_merge u_merge (
        .i_word   (Data_out),
        .i_wdata  (r_wdata),
        .i_lane   (r_lane),
        .i_op     (r_op),
        .o_merged (w_merged),
        .o_load   (w_load)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !w_accept ? S_IDLE : w_err ? S_RESP : bus.req_op == OP_SW ? S_WR : S_RD;
            S_RD:    w_next = is_rmw(r_op) ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory address/data registers are loaded only when a real access follows, so they hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_LW;
            r_lane   <= 2'b00;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_daddr  <= DATA_BASE;
            r_datain <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= bus.req_op;
                r_lane  <= bus.req_addr[1:0];
                r_wdata <= bus.req_wdata;
                r_err   <= w_err;
                r_rdata <= '0;
                if (!w_err)
                    r_daddr <= DATA_BASE + w_woff;
                if (!w_err && bus.req_op == OP_SW)
                    r_datain <= bus.req_wdata;
            end
            if (r_state == S_RD) begin
                if (is_rmw(r_op))
                    r_datain <= w_merged;
                else
                    r_rdata <= w_load;
            end
        end
    end
endmodule
